// File: rtl/debounce_pkg.sv
// Shared constants for the input debouncer: FSM state encoding and default sizes.
// No logic here; imported by debounce_channel and input_debouncer.
package debounce_pkg;

  // Bit 1 of the state is the clean level, so clean_out falls straight out of the encoding.
  localparam logic [1:0] IDLE_LO = 2'b00;
  localparam logic [1:0] CNT_HI  = 2'b01;
  localparam logic [1:0] IDLE_HI = 2'b11;
  localparam logic [1:0] CNT_LO  = 2'b10;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/debounce_channel.sv
// One debounced bit: synchroniser chain, 4-state stability FSM and counter; edge pulses with DEBOUNCE_EDGE_EN.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES+1 edges (sampling edge counted); no backpressure, free-running input.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] LP_DB_CNT = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_clean;
  logic [1:0]             w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_s;

  always_ff @(posedge clk) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      IDLE_LO: begin
        if (w_s) begin
          w_state_nxt = CNT_HI;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      CNT_HI: begin
        if (!w_s)                    w_state_nxt = IDLE_LO;
        else if (r_cnt == LP_DB_CNT) w_state_nxt = IDLE_HI;
        else                         w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      IDLE_HI: begin
        if (!w_s) begin
          w_state_nxt = CNT_LO;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      CNT_LO: begin
        if (w_s)                     w_state_nxt = IDLE_HI;
        else if (r_cnt == LP_DB_CNT) w_state_nxt = IDLE_LO;
        else                         w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      default: begin
        w_state_nxt = IDLE_LO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE_LO;
      r_cnt   <= '0;
      r_clean <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_clean <= w_state_nxt[1];
    end
  end

  assign o_clean = r_clean;

`ifdef DEBOUNCE_EDGE_EN
  logic r_rise;
  logic r_fall;

  // Pulses are set on the same edge that commits the new clean level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= (r_state == CNT_HI) && (w_state_nxt == IDLE_HI);
      r_fall <= (r_state == CNT_LO) && (w_state_nxt == IDLE_LO);
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/input_debouncer.sv
// Debounces NUM_CH independent raw inputs into clean levels (+ edge pulses when DEBOUNCE_EDGE_EN is defined).
// Latency SYNC_STAGES+DEBOUNCE_CYCLES+1 edges per channel; no backpressure, inputs are free-running levels.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] clean_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("input_debouncer: NUM_CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("input_debouncer: SYNC_STAGES must be >= 2");
  end
  if (CNT_W < 1 || CNT_W > 30) begin : g_bad_cnt_w
    $error("input_debouncer: CNT_W out of supported range");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES >= (1 << CNT_W)) begin : g_bad_db
    $error("input_debouncer: DEBOUNCE_CYCLES must satisfy 1 <= value < 2**CNT_W");
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_raw  (raw_in[gi]),
      .o_clean(clean_out[gi]),
      .o_rise (rise_pulse[gi]),
      .o_fall (fall_pulse[gi])
    );
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios then random stimulus against a sample-window reference model.
module tb_input_debouncer;

  localparam int NCH  = 2;
  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int CW   = 4;
  localparam int HL   = SYNC + DB + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [NCH-1:0] raw_in;
  logic [NCH-1:0] clean_out;
  logic [NCH-1:0] rise_pulse;
  logic [NCH-1:0] fall_pulse;

  input_debouncer #(
    .NUM_CH         (NCH),
    .SYNC_STAGES    (SYNC),
    .CNT_W          (CW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  int checks   = 0;
  int failures = 0;

  // hist[ch][k] = raw value sampled k edges ago (k=0 is the current edge).
  bit hist    [NCH][HL];
  bit m_clean [NCH];
  bit m_rise  [NCH];
  bit m_fall  [NCH];
  int rise_seen [NCH];
  int fall_seen [NCH];

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // A level is accepted once the FSM has seen DB+1 consecutive samples of it;
  // the FSM sees the raw input SYNC edges late.
  task automatic model_edge();
    for (int ch = 0; ch < NCH; ch++) begin
      m_rise[ch] = 1'b0;
      m_fall[ch] = 1'b0;
      if (!rst_n) begin
        for (int k = 0; k < HL; k++) hist[ch][k] = 1'b0;
        m_clean[ch] = 1'b0;
      end else begin
        bit all_opp;
        for (int k = HL - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
        hist[ch][0] = raw_in[ch];
        all_opp = 1'b1;
        for (int k = SYNC; k < HL; k++)
          if (hist[ch][k] == m_clean[ch]) all_opp = 1'b0;
        if (all_opp) begin
          m_clean[ch] = ~m_clean[ch];
          m_rise[ch]  = m_clean[ch];
          m_fall[ch]  = ~m_clean[ch];
        end
      end
    end
  endtask

  task automatic tick();
    logic exp_r, exp_f;
    @(posedge clk);
    model_edge();
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
`ifdef DEBOUNCE_EDGE_EN
      exp_r = m_rise[ch];
      exp_f = m_fall[ch];
`else
      exp_r = 1'b0;
      exp_f = 1'b0;
`endif
      check_bit($sformatf("clean_out[%0d]", ch), clean_out[ch], m_clean[ch]);
      check_bit($sformatf("rise_pulse[%0d]", ch), rise_pulse[ch], exp_r);
      check_bit($sformatf("fall_pulse[%0d]", ch), fall_pulse[ch], exp_f);
      if (rise_pulse[ch] === 1'b1) rise_seen[ch]++;
      if (fall_pulse[ch] === 1'b1) fall_seen[ch]++;
    end
  endtask

  // Counts edges (the first sampling edge is edge 1) until clean_out[ch]==lvl.
  task automatic edges_until(input int ch, input logic lvl, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (clean_out[ch] !== lvl && n < 30);
  endtask

  int n;
  int r0, f0;
  int exp_pulse;
  bit seen_hi;
  int hold [NCH];

  initial begin
`ifdef DEBOUNCE_EDGE_EN
    exp_pulse = 1;
`else
    exp_pulse = 0;
`endif
    for (int ch = 0; ch < NCH; ch++) begin
      rise_seen[ch] = 0;
      fall_seen[ch] = 0;
      hold[ch]      = 0;
    end

    // Reset held with both raw inputs high.
    rst_n  = 1'b0;
    raw_in = 2'b11;
    #1;
    repeat (3) tick();
    check_int("reset_clean", int'(clean_out), 0);
    rst_n  = 1'b1;
    raw_in = 2'b00;
    repeat (8) tick();
    check_int("idle_clean", int'(clean_out), 0);

    // Latency on channel 0.
    r0 = rise_seen[0];
    raw_in[0] = 1'b1;
    edges_until(0, 1'b1, n);
    check_int("latency_rise0", n, SYNC + DB + 1);
    check_int("latency_rise_pulses0", rise_seen[0] - r0, exp_pulse);
    repeat (4) tick();

    // Glitch of DB cycles on channel 1 is rejected.
    raw_in[1] = 1'b1;
    repeat (DB) tick();
    raw_in[1] = 1'b0;
    repeat (10) tick();
    check_bit("glitch4_clean1", clean_out[1], 1'b0);
    check_int("glitch4_pulses1", rise_seen[1] + fall_seen[1], 0);

    // DB+1 cycles is accepted, then falls SYNC+DB+1 edges after the drop.
    raw_in[1] = 1'b1;
    repeat (DB + 1) tick();
    raw_in[1] = 1'b0;
    n = 0;
    seen_hi = 1'b0;
    do begin
      tick();
      n++;
      if (clean_out[1] === 1'b1) seen_hi = 1'b1;
    end while (!(seen_hi && clean_out[1] === 1'b0) && n < 30);
    check_bit("glitch5_seen_high1", seen_hi, 1'b1);
    check_int("glitch5_fall_latency1", n, SYNC + DB + 1);
    repeat (4) tick();

    // Bounce on channel 0: bring it low first, then 1,0,1,0,1 and hold.
    raw_in[0] = 1'b0;
    repeat (10) tick();
    check_bit("bounce_pre_clean0", clean_out[0], 1'b0);
    r0 = rise_seen[0];
    for (int i = 0; i < 4; i++) begin
      raw_in[0] = ~i[0];
      tick();
    end
    raw_in[0] = 1'b1;
    edges_until(0, 1'b1, n);
    check_int("bounce_latency0", n, SYNC + DB + 1);
    repeat (6) tick();
    check_int("bounce_rise_pulses0", rise_seen[0] - r0, exp_pulse);

    // Reset mid-count on channel 0.
    raw_in[0] = 1'b0;
    repeat (10) tick();
    r0 = rise_seen[0];
    f0 = fall_seen[0];
    raw_in[0] = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check_bit("midreset_clean0", clean_out[0], 1'b0);
    rst_n = 1'b1;
    check_int("midreset_no_pulse0", rise_seen[0] - r0, 0);
    edges_until(0, 1'b1, n);
    check_int("midreset_latency0", n, SYNC + DB + 1);
    check_int("midreset_rise_pulses0", rise_seen[0] - r0, exp_pulse);
    check_int("midreset_fall_pulses0", fall_seen[0] - f0, 0);

    // Random levels of random hold length with rare resets.
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (hold[ch] == 0) begin
          raw_in[ch] = 1'($urandom);
          hold[ch]   = int'($urandom_range(1, 9));
        end else begin
          hold[ch]--;
        end
      end
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
